// File: rtl/sr_latch_pkg.sv
// rtl/sr_latch_pkg.sv - shared types and constants for the SR latch write sequencer
//
// Contents:
//   state_t    - write sequencer FSM states
//   OP_SET     - request opcode that sets the latch
//   OP_RESET   - request opcode that resets the latch
//   CHECK_CYC  - length of the readback window
package sr_latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    // Two synchronizer stages plus one cycle of margin.
    localparam int CHECK_CYC = 3;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous input
//
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears both stages
//   d      - asynchronous input
//   q      - synchronized output, two clk cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_writer.sv
// rtl/sr_latch_writer.sv - sequences S/R/enable writes to an external gated SR latch and verifies readback
//
// Parameters:
//   SETUP_CYC  - cycles S/R are held with latch_en low before the pulse (1..15)
//   PULSE_CYC  - cycles latch_en is held high (1..15)
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid, req_op    - write request, op 1 = set, 0 = reset
//   req_ready            - high only while idle
//   latch_s/r/en         - registered drives to the external latch
//   latch_q, latch_qbar  - asynchronous readback from the latch
//   done, err            - one-cycle completion pulse, err marks a readback mismatch
//   err_cnt              - saturating count of err pulses
module sr_latch_writer
    import sr_latch_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_op,
    output logic       req_ready,
    output logic       latch_s,
    output logic       latch_r,
    output logic       latch_en,
    input  logic       latch_q,
    input  logic       latch_qbar,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    // The final readback cycle is the one in which done is presented from
    // IDLE, so the CHECK state itself only occupies CHECK_CYC-1 cycles and
    // the comparison is taken on the edge that leaves it.
    localparam logic [3:0] CHECK_LAST = 4'(CHECK_CYC - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       op_q;
    logic       q_sync;
    logic       qbar_sync;
    logic       pass;

    sync2 u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (latch_q),
        .q     (q_sync)
    );

    sync2 u_sync_qbar (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (latch_qbar),
        .q     (qbar_sync)
    );

    // q == qbar (invalid or metastable latch) can never satisfy both terms.
    assign pass = (q_sync == op_q) && (qbar_sync == ~op_q);

    // S/R are loaded from the same op bit as complements and cleared
    // together, so they can never both be high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            op_q      <= OP_RESET;
            req_ready <= 1'b0;
            latch_s   <= 1'b0;
            latch_r   <= 1'b0;
            latch_en  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        latch_s   <= req_op;
                        latch_r   <= ~req_op;
                        req_ready <= 1'b0;
                        cnt       <= 4'd0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt      <= 4'd0;
                        latch_en <= 1'b1;
                        state    <= ST_PULSE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt      <= 4'd0;
                        latch_en <= 1'b0;
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    // Enable already dropped last edge; release S/R only now.
                    latch_s <= 1'b0;
                    latch_r <= 1'b0;
                    cnt     <= 4'd0;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cnt == CHECK_LAST) begin
                        cnt       <= 4'd0;
                        done      <= 1'b1;
                        err       <= ~pass;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                        if (!pass && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                    latch_s   <= 1'b0;
                    latch_r   <= 1'b0;
                    latch_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule
